// File: rtl/core_boot_ctrl.sv
// core_boot_ctrl - boot and reset sequencer for arcade cores.
//
// Watches the data_io download stream and tracks, for each download
// index, whether it has completed at least once. It also counts the bytes
// of the current or last download and checks the main ROM image against a
// minimum size. The core is held in reset until a valid ROM is present,
// and then for HOLD_CYCLES more cycles after any release condition.
//
// Ports:
//   clk_sys        system clock
//   reset          synchronous active-high full reset (clears loaded flags)
//   user_reset     soft reset request; keeps the loaded flags
//   ioctl_download download active
//   ioctl_index    download index (latched when a download starts)
//   ioctl_wr       one-cycle byte write strobe
//   ioctl_addr     byte address; the last written address is captured
//   core_reset     registered active-high reset to the core
//   rom_loaded     a ROM image of at least ROM_MIN_SIZE bytes is present
//   rom_error      the last ROM download ended short
//   idx_loaded     per-index "completed at least once"
//   byte_count     bytes written in the current/last download (saturating)
//   last_addr      ioctl_addr of the last write in the current/last download
//   busy           download in progress
module core_boot_ctrl #(
  parameter int NUM_IDX      = 2,
  parameter int ROM_IDX      = 0,
  parameter int ROM_MIN_SIZE = 32768,
  parameter int HOLD_CYCLES  = 4800,
  parameter int RESET_ON_AUX = 0,
  parameter int CW           = 25
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               user_reset,
  input  logic               ioctl_download,
  input  logic [7:0]         ioctl_index,
  input  logic               ioctl_wr,
  input  logic [24:0]        ioctl_addr,
  output logic               core_reset,
  output logic               rom_loaded,
  output logic               rom_error,
  output logic [NUM_IDX-1:0] idx_loaded,
  output logic [CW-1:0]      byte_count,
  output logic [24:0]        last_addr,
  output logic               busy
);

  typedef enum logic [1:0] {EMPTY, LOAD, HOLD, RUN} state_t;

  localparam int HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int CW1 = CW + 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  // One extra bit so the size check cannot wrap against the counter width.
  localparam logic [CW:0]   ROM_MIN   = CW1'(ROM_MIN_SIZE);

  state_t              state_q, state_d;
  logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
  logic                dl_q, dl_d;
  logic [7:0]          cur_idx_q, cur_idx_d;
  logic                busy_q, busy_d;
  logic [CW-1:0]       byte_count_q, byte_count_d;
  logic [24:0]         last_addr_q, last_addr_d;
  logic                rom_loaded_q, rom_loaded_d;
  logic                rom_error_q, rom_error_d;
  logic [NUM_IDX-1:0]  idx_loaded_q, idx_loaded_d;
  logic                core_reset_q, core_reset_d;

  logic start, end_ev, start_rom, end_rom, wr_cnt, rom_valid;

  assign start     = ioctl_download & ~dl_q;
  assign end_ev    = ~ioctl_download & dl_q;
  assign start_rom = start & (ioctl_index == 8'(ROM_IDX));
  assign end_rom   = end_ev & (cur_idx_q == 8'(ROM_IDX));
  assign wr_cnt    = busy_q & ioctl_wr;

  // Download tracking: counting, flags and size check, then the sequencer.
  // The size check uses the updated byte count so that a write landing on
  // the same cycle as the end of the download is included.
  always_comb begin
    dl_d         = ioctl_download;
    cur_idx_d    = cur_idx_q;
    busy_d       = busy_q;
    byte_count_d = byte_count_q;
    last_addr_d  = last_addr_q;
    rom_loaded_d = rom_loaded_q;
    rom_error_d  = rom_error_q;
    idx_loaded_d = idx_loaded_q;
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    rom_valid    = rom_loaded_q;

    if (start) begin
      cur_idx_d    = ioctl_index;
      byte_count_d = '0;
      busy_d       = 1'b1;
      if (start_rom) begin
        rom_loaded_d = 1'b0;
        rom_error_d  = 1'b0;
      end
    end

    if (wr_cnt) begin
      if (byte_count_q != '1) byte_count_d = byte_count_q + 1'b1;
      last_addr_d = ioctl_addr;
    end

    if (end_ev) begin
      busy_d = 1'b0;
      for (int i = 0; i < NUM_IDX; i++) begin
        if (cur_idx_q == 8'(i)) idx_loaded_d[i] = 1'b1;
      end
      if (end_rom) begin
        rom_valid = ({1'b0, byte_count_d} >= ROM_MIN);
        if (rom_valid) rom_loaded_d = 1'b1;
        else           rom_error_d  = 1'b1;
      end
    end

    case (state_q)
      EMPTY: begin
        if (rom_loaded_q) begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      LOAD: begin
        if (end_ev) begin
          if (rom_valid) begin
            state_d    = HOLD;
            hold_cnt_d = HOLD_LOAD;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      HOLD: begin
        if (user_reset)            hold_cnt_d = HOLD_LOAD;
        else if (hold_cnt_q == '0) state_d    = RUN;
        else                       hold_cnt_d = hold_cnt_q - 1'b1;
      end
      RUN: begin
        if (user_reset) begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      default: state_d = EMPTY;
    endcase

    // A download that must hold the core wins over everything else.
    if (start_rom || (start && (RESET_ON_AUX != 0))) state_d = LOAD;

    core_reset_d = (state_d != RUN);
  end

  // State register; reset wins over any event in the same cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= EMPTY;
      hold_cnt_q   <= '0;
      dl_q         <= 1'b0;
      cur_idx_q    <= '0;
      busy_q       <= 1'b0;
      byte_count_q <= '0;
      last_addr_q  <= '0;
      rom_loaded_q <= 1'b0;
      rom_error_q  <= 1'b0;
      idx_loaded_q <= '0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      dl_q         <= dl_d;
      cur_idx_q    <= cur_idx_d;
      busy_q       <= busy_d;
      byte_count_q <= byte_count_d;
      last_addr_q  <= last_addr_d;
      rom_loaded_q <= rom_loaded_d;
      rom_error_q  <= rom_error_d;
      idx_loaded_q <= idx_loaded_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign core_reset = core_reset_q;
  assign rom_loaded = rom_loaded_q;
  assign rom_error  = rom_error_q;
  assign idx_loaded = idx_loaded_q;
  assign byte_count = byte_count_q;
  assign last_addr  = last_addr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_core_boot_ctrl.sv
// tb_core_boot_ctrl - directed bench for core_boot_ctrl.
// Two instances share one stimulus stream: "a" has RESET_ON_AUX=0 and
// "b" has RESET_ON_AUX=1. Both use NUM_IDX=2, ROM_MIN_SIZE=16 and
// HOLD_CYCLES=4.
module tb_core_boot_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        user_reset = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;

  logic        a_core_reset, a_rom_loaded, a_rom_error, a_busy;
  logic [1:0]  a_idx_loaded;
  logic [24:0] a_byte_count, a_last_addr;
  logic        b_core_reset, b_rom_loaded, b_rom_error, b_busy;
  logic [1:0]  b_idx_loaded;
  logic [24:0] b_byte_count, b_last_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk_sys = ~clk_sys;

  core_boot_ctrl #(.NUM_IDX(2), .ROM_IDX(0), .ROM_MIN_SIZE(16), .HOLD_CYCLES(4),
                   .RESET_ON_AUX(0), .CW(25)) dut_a (
    .clk_sys(clk_sys), .reset(reset), .user_reset(user_reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .core_reset(a_core_reset), .rom_loaded(a_rom_loaded), .rom_error(a_rom_error),
    .idx_loaded(a_idx_loaded), .byte_count(a_byte_count), .last_addr(a_last_addr),
    .busy(a_busy)
  );

  core_boot_ctrl #(.NUM_IDX(2), .ROM_IDX(0), .ROM_MIN_SIZE(16), .HOLD_CYCLES(4),
                   .RESET_ON_AUX(1), .CW(25)) dut_b (
    .clk_sys(clk_sys), .reset(reset), .user_reset(user_reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .core_reset(b_core_reset), .rom_loaded(b_rom_loaded), .rom_error(b_rom_error),
    .idx_loaded(b_idx_loaded), .byte_count(b_byte_count), .last_addr(b_last_addr),
    .busy(b_busy)
  );

  // Drive one cycle of inputs, then wait until just after the capturing edge.
  task automatic applyStimulus(input logic dl, input logic [7:0] idx, input logic wr,
                               input logic [24:0] addr, input logic ur, input logic rst);
    ioctl_download = dl;
    ioctl_index    = idx;
    ioctl_wr       = wr;
    ioctl_addr     = addr;
    user_reset     = ur;
    reset          = rst;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'd0, 1'b0, 25'd0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full download of n bytes at addresses 0..n-1; returns after the end edge.
  task automatic download(input logic [7:0] idx, input int n);
    applyStimulus(1'b1, idx, 1'b0, 25'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, idx, 1'b1, 25'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, idx, 1'b0, 25'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset and idle.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'd0, 1'b0, 25'd0, 1'b0, 1'b1);
    idle(20);
    checkOutput("rst_core_reset", 32'(a_core_reset), 32'd1);
    checkOutput("rst_rom_loaded", 32'(a_rom_loaded), 32'd0);
    checkOutput("rst_rom_error", 32'(a_rom_error), 32'd0);
    checkOutput("rst_idx_loaded", 32'(a_idx_loaded), 32'd0);
    checkOutput("rst_byte_count", 32'(a_byte_count), 32'd0);
    checkOutput("rst_busy", 32'(a_busy), 32'd0);

    // First ROM load, exactly the minimum size.
    applyStimulus(1'b1, 8'd0, 1'b0, 25'd0, 1'b0, 1'b0);
    checkOutput("dl1_busy", 32'(a_busy), 32'd1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'd0, 1'b1, 25'(i), 1'b0, 1'b0);
    checkOutput("dl1_no_flag_yet", 32'(a_rom_loaded), 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 25'd0, 1'b0, 1'b0);
    checkOutput("dl1_rom_loaded", 32'(a_rom_loaded), 32'd1);
    checkOutput("dl1_byte_count", 32'(a_byte_count), 32'd16);
    checkOutput("dl1_last_addr", 32'(a_last_addr), 32'd15);
    checkOutput("dl1_idx_loaded", 32'(a_idx_loaded), 32'd1);
    checkOutput("dl1_busy_off", 32'(a_busy), 32'd0);
    checkOutput("dl1_hold1", 32'(a_core_reset), 32'd1);
    idle(3);
    checkOutput("dl1_hold4", 32'(a_core_reset), 32'd1);
    idle(1);
    checkOutput("dl1_release", 32'(a_core_reset), 32'd0);

    // Short ROM download keeps the core in reset.
    applyStimulus(1'b1, 8'd0, 1'b0, 25'd0, 1'b0, 1'b0);
    checkOutput("short_start_clr", 32'(a_rom_loaded), 32'd0);
    checkOutput("short_start_rst", 32'(a_core_reset), 32'd1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'd0, 1'b1, 25'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 25'd0, 1'b0, 1'b0);
    checkOutput("short_rom_error", 32'(a_rom_error), 32'd1);
    checkOutput("short_rom_loaded", 32'(a_rom_loaded), 32'd0);
    checkOutput("short_byte_count", 32'(a_byte_count), 32'd10);
    idle(10);
    checkOutput("short_stay_reset", 32'(a_core_reset), 32'd1);

    // 20-byte reload recovers.
    download(8'd0, 20);
    checkOutput("dl20_rom_error", 32'(a_rom_error), 32'd0);
    checkOutput("dl20_rom_loaded", 32'(a_rom_loaded), 32'd1);
    checkOutput("dl20_byte_count", 32'(a_byte_count), 32'd20);
    checkOutput("dl20_last_addr", 32'(a_last_addr), 32'd19);
    idle(3);
    checkOutput("dl20_hold4", 32'(a_core_reset), 32'd1);
    idle(1);
    checkOutput("dl20_release", 32'(a_core_reset), 32'd0);

    // Zero-length ROM download is an error.
    download(8'd0, 0);
    checkOutput("zero_rom_error", 32'(a_rom_error), 32'd1);
    checkOutput("zero_byte_count", 32'(a_byte_count), 32'd0);
    idle(6);
    checkOutput("zero_stay_reset", 32'(a_core_reset), 32'd1);

    // 15 writes plus a 16th on the same cycle the download drops.
    applyStimulus(1'b1, 8'd0, 1'b0, 25'd0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 8'd0, 1'b1, 25'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 25'd15, 1'b0, 1'b0);
    checkOutput("endwr_byte_count", 32'(a_byte_count), 32'd16);
    checkOutput("endwr_last_addr", 32'(a_last_addr), 32'd15);
    checkOutput("endwr_rom_loaded", 32'(a_rom_loaded), 32'd1);
    idle(4);
    checkOutput("endwr_release", 32'(a_core_reset), 32'd0);

    // user_reset pulse of 3 cycles in RUN.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 25'd0, 1'b1, 1'b0);
      checkOutput("ures_during", 32'(a_core_reset), 32'd1);
    end
    idle(3);
    checkOutput("ures_hold", 32'(a_core_reset), 32'd1);
    idle(1);
    checkOutput("ures_release", 32'(a_core_reset), 32'd0);
    checkOutput("ures_rom_loaded", 32'(a_rom_loaded), 32'd1);

    // Aux download of index 1, 5 bytes: a keeps running, b is held.
    applyStimulus(1'b1, 8'd1, 1'b0, 25'd0, 1'b0, 1'b0);
    checkOutput("aux_a_run", 32'(a_core_reset), 32'd0);
    checkOutput("aux_b_held", 32'(b_core_reset), 32'd1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'd1, 1'b1, 25'(100 + i), 1'b0, 1'b0);
    // ioctl_index change at the end must be ignored (latched at start).
    applyStimulus(1'b0, 8'd0, 1'b0, 25'd0, 1'b0, 1'b0);
    checkOutput("aux_a_end_run", 32'(a_core_reset), 32'd0);
    checkOutput("aux_idx_loaded", 32'(a_idx_loaded), 32'd3);
    checkOutput("aux_byte_count", 32'(a_byte_count), 32'd5);
    checkOutput("aux_last_addr", 32'(a_last_addr), 32'd104);
    checkOutput("aux_rom_kept", 32'(a_rom_loaded), 32'd1);
    checkOutput("aux_b_idx_loaded", 32'(b_idx_loaded), 32'd3);
    checkOutput("aux_b_end_hold", 32'(b_core_reset), 32'd1);
    idle(3);
    checkOutput("aux_b_hold4", 32'(b_core_reset), 32'd1);
    idle(1);
    checkOutput("aux_b_release", 32'(b_core_reset), 32'd0);

    // Reset during a ROM download at write 8 of 16.
    applyStimulus(1'b1, 8'd0, 1'b0, 25'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'd0, 1'b1, 25'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd0, 1'b1, 25'd7, 1'b0, 1'b1);
    checkOutput("mid_core_reset", 32'(a_core_reset), 32'd1);
    checkOutput("mid_rom_loaded", 32'(a_rom_loaded), 32'd0);
    checkOutput("mid_idx_loaded", 32'(a_idx_loaded), 32'd0);
    checkOutput("mid_byte_count", 32'(a_byte_count), 32'd0);
    checkOutput("mid_last_addr", 32'(a_last_addr), 32'd0);
    checkOutput("mid_busy", 32'(a_busy), 32'd0);
    applyStimulus(1'b1, 8'd0, 1'b0, 25'd0, 1'b0, 1'b0);
    checkOutput("restart_busy", 32'(a_busy), 32'd1);
    checkOutput("restart_count0", 32'(a_byte_count), 32'd0);
    applyStimulus(1'b1, 8'd0, 1'b1, 25'd40, 1'b0, 1'b0);
    checkOutput("restart_count1", 32'(a_byte_count), 32'd1);
    checkOutput("restart_addr", 32'(a_last_addr), 32'd40);
    for (int i = 1; i < 16; i++) applyStimulus(1'b1, 8'd0, 1'b1, 25'(40 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 25'd0, 1'b0, 1'b0);
    checkOutput("restart_rom_loaded", 32'(a_rom_loaded), 32'd1);
    checkOutput("restart_byte_count", 32'(a_byte_count), 32'd16);
    checkOutput("restart_idx_loaded", 32'(a_idx_loaded), 32'd1);
    idle(4);
    checkOutput("restart_release", 32'(a_core_reset), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
